// File: rtl/i2c_types_pkg.sv
// Shared types for the I2C byte master: command codes, FSM states and
// the SCL/SDA level table for each command phase.
package i2c_types_pkg;

  localparam int unsigned CLK_DIV_DEFAULT = 32'd250;

  typedef enum logic [2:0] {
    CMD_START     = 3'd0,
    CMD_STOP      = 3'd1,
    CMD_WRITE     = 3'd2,
    CMD_READ_ACK  = 3'd3,
    CMD_READ_NACK = 3'd4
  } i2c_cmd_t;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WRITE = 3'd2,
    ST_READ  = 3'd3,
    ST_STOP  = 3'd4
  } i2c_state_t;

  // Returns {scl, sda} for a state and quarter phase; cell_bit is the data-cell SDA level.
  function automatic logic [1:0] bus_levels(input i2c_state_t st, input logic [1:0] ph,
                                            input logic cell_bit);
    logic [1:0] lv;
    case (st)
      ST_START: lv = {(ph < 2'd2), (ph == 2'd0)};
      ST_STOP:  lv = {(ph != 2'd0), (ph >= 2'd2)};
      ST_WRITE,
      ST_READ:  lv = {((ph == 2'd1) || (ph == 2'd2)), cell_bit};
      default:  lv = 2'b11;
    endcase
    return lv;
  endfunction

endpackage

// File: rtl/i2c_quarter_timer.sv
// Quarter-period timer: reloads on load, freezes while hold is high and
// emits a registered one-cycle tick each time the count expires.
module i2c_quarter_timer #(
  parameter int unsigned CLK_DIV = 32'd250
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic load,
  input  logic hold,
  output logic tick
);

  localparam logic [15:0] RELOAD = 16'(CLK_DIV - 32'd1);

  logic [15:0] count_r;
  logic        tick_r;

  // Down-counter with load priority over hold.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      count_r <= 16'd0;
      tick_r  <= 1'b0;
    end else if (load) begin
      count_r <= RELOAD;
      tick_r  <= 1'b0;
    end else if (hold) begin
      count_r <= count_r;
      tick_r  <= 1'b0;
    end else if (count_r == 16'd0) begin
      count_r <= RELOAD;
      tick_r  <= 1'b1;
    end else begin
      count_r <= count_r - 16'd1;
      tick_r  <= 1'b0;
    end
  end

  assign tick = tick_r;

endmodule

// File: rtl/i2c_byte_master.sv
// Single-master I2C byte engine: START / STOP / WRITE / READ commands on an
// open-drain bus, with clock stretching and write-side arbitration detection.
module i2c_byte_master
  import i2c_types_pkg::*;
#(
  parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  i2c_cmd_t   cmd_i,
  input  logic       cmd_valid_i,
  output logic       cmd_ready_o,
  input  logic [7:0] wdata_i,
  output logic [7:0] rdata_o,
  output logic       done_o,
  output logic       nack_o,
  output logic       arb_lost_o,
  output logic       bus_busy_o,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       scl_o,
  output logic       sda_o
);

  i2c_state_t  state_r, state_next_s;
  logic [1:0]  phase_r;
  logic [3:0]  bit_idx_r;
  logic [7:0]  shift_r, rdata_r;
  logic        read_ack_r, nack_r;
  logic        scl_r, sda_r, ready_r, done_r, arb_r, busy_r;
  logic        scl_s, sda_s, done_s, busy_s, cell_bit_s;
  logic        accept_s, tick_s, stretch_s, hold_s, sample_s, cmd_end_s, arb_s;
  logic [2:0]  bit_sel_s;

  assign accept_s  = cmd_valid_i && (state_r == ST_IDLE);
  assign stretch_s = (state_r != ST_IDLE) && ((phase_r == 2'd1) || (phase_r == 2'd2))
                     && scl_r && !scl_i;
  assign hold_s    = (state_r == ST_IDLE) || stretch_s;
  assign sample_s  = tick_s && (phase_r == 2'd1);
  // Start/stop end after one cell; byte commands after the ninth (ACK) cell.
  assign cmd_end_s = tick_s && (phase_r == 2'd3) &&
                     ((state_r == ST_START) || (state_r == ST_STOP) || (bit_idx_r == 4'd0));
  assign arb_s     = sample_s && (state_r == ST_WRITE) && (bit_idx_r != 4'd0) && sda_r && !sda_i;
  assign bit_sel_s = 3'(bit_idx_r - 4'd1);

  i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (accept_s),
    .hold  (hold_s),
    .tick  (tick_s)
  );

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!rst_i) state_r <= ST_IDLE;
    else        state_r <= state_next_s;
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_valid_i) begin
          case (cmd_i)
            CMD_START:     state_next_s = ST_START;
            CMD_STOP:      state_next_s = ST_STOP;
            CMD_WRITE:     state_next_s = ST_WRITE;
            CMD_READ_ACK,
            CMD_READ_NACK: state_next_s = ST_READ;
            default:       state_next_s = ST_IDLE;
          endcase
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_START, ST_STOP, ST_WRITE, ST_READ: begin
        if (arb_s || cmd_end_s) state_next_s = ST_IDLE;
        else                    state_next_s = state_r;
      end
      default: state_next_s = ST_IDLE;
    endcase
  end

  // SDA level for the current bit cell.
  always_comb begin
    cell_bit_s = 1'b1;
    if (state_r == ST_WRITE) begin
      if (bit_idx_r != 4'd0) cell_bit_s = shift_r[bit_sel_s];
      else                   cell_bit_s = 1'b1;
    end else if (state_r == ST_READ) begin
      if (bit_idx_r != 4'd0) cell_bit_s = 1'b1;
      else                   cell_bit_s = ~read_ack_r;
    end else begin
      cell_bit_s = 1'b1;
    end
  end

  // FSM outputs; lines keep their last level while idle so SCL stays held between commands.
  always_comb begin
    scl_s  = scl_r;
    sda_s  = sda_r;
    done_s = 1'b0;
    busy_s = busy_r;
    if (arb_s) begin
      scl_s  = 1'b1;
      sda_s  = 1'b1;
      busy_s = 1'b0;
    end else if (state_r != ST_IDLE) begin
      {scl_s, sda_s} = bus_levels(state_r, phase_r, cell_bit_s);
      if (cmd_end_s) begin
        done_s = 1'b1;
        if (state_r == ST_START)     busy_s = 1'b1;
        else if (state_r == ST_STOP) busy_s = 1'b0;
        else                         busy_s = busy_r;
      end else begin
        done_s = 1'b0;
      end
    end else begin
      scl_s = scl_r;
      sda_s = sda_r;
    end
  end

  // Phase/bit sequencing, data shifting and result capture.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      phase_r    <= 2'd0;
      bit_idx_r  <= 4'd8;
      shift_r    <= 8'h00;
      read_ack_r <= 1'b0;
      rdata_r    <= 8'h00;
      nack_r     <= 1'b0;
    end else if (accept_s) begin
      phase_r    <= 2'd0;
      bit_idx_r  <= 4'd8;
      shift_r    <= wdata_i;
      read_ack_r <= (cmd_i == CMD_READ_ACK);
    end else if (state_r != ST_IDLE) begin
      if (sample_s && (state_r == ST_READ) && (bit_idx_r != 4'd0))
        shift_r <= {shift_r[6:0], sda_i};
      if (sample_s && (state_r == ST_WRITE) && (bit_idx_r == 4'd0))
        nack_r <= sda_i;
      if (cmd_end_s && (state_r == ST_READ))
        rdata_r <= shift_r;
      if (tick_s) begin
        phase_r <= phase_r + 2'd1;
        if ((phase_r == 2'd3) && (bit_idx_r != 4'd0)) bit_idx_r <= bit_idx_r - 4'd1;
      end
    end
  end

  // Registered outputs.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      scl_r   <= 1'b1;
      sda_r   <= 1'b1;
      ready_r <= 1'b1;
      done_r  <= 1'b0;
      arb_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      scl_r   <= scl_s;
      sda_r   <= sda_s;
      ready_r <= (state_next_s == ST_IDLE);
      done_r  <= done_s;
      arb_r   <= arb_s;
      busy_r  <= busy_s;
    end
  end

  assign scl_o       = scl_r;
  assign sda_o       = sda_r;
  assign cmd_ready_o = ready_r;
  assign done_o      = done_r;
  assign arb_lost_o  = arb_r;
  assign bus_busy_o  = busy_r;
  assign rdata_o     = rdata_r;
  assign nack_o      = nack_r;

endmodule

// File: tb/tb_i2c_byte_master.sv
// Bench for i2c_byte_master: open-drain bus with a small slave model,
// scoreboard queue of expected results checked after each command.
module tb_i2c_byte_master;
  import i2c_types_pkg::*;

  localparam int CD = 4;

  logic       clk = 1'b0;
  logic       rst_i = 1'b0;
  i2c_cmd_t   cmd = CMD_START;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [7:0] wdata = 8'h00;
  logic [7:0] rdata;
  logic       done_o, nack_o, arb_lost_o, bus_busy_o;
  logic       scl_o, sda_o, scl_i, sda_i;

  int checks = 0;
  int failures = 0;
  int sb_q[$];

  // Slave configuration (written by the stimulus only): 0 none, 1 ACK writes, 2 send slave_byte.
  int         slave_mode = 0;
  logic [7:0] slave_byte = 8'h00;
  bit         stretch_en = 1'b0;
  bit         force_low = 1'b0;

  // Slave/monitor state (written by the monitor only).
  int   rise_n, fall_n, hcnt;
  bit   armed, scl_q;
  logic slave_sda;
  logic cap [16];

  assign scl_i = scl_o & ~armed;
  assign sda_i = sda_o & slave_sda & ~force_low;

  always #5 clk = ~clk;

  i2c_byte_master #(.CLK_DIV(CD)) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .cmd_i       (cmd),
    .cmd_valid_i (cmd_valid),
    .cmd_ready_o (cmd_ready),
    .wdata_i     (wdata),
    .rdata_o     (rdata),
    .done_o      (done_o),
    .nack_o      (nack_o),
    .arb_lost_o  (arb_lost_o),
    .bus_busy_o  (bus_busy_o),
    .scl_i       (scl_i),
    .sda_i       (sda_i),
    .scl_o       (scl_o),
    .sda_o       (sda_o)
  );

  // Slave model: captures SDA on SCL rises, drives data/ACK after SCL falls, stretches SCL.
  always @(posedge clk) begin
    if (!rst_i) begin
      rise_n <= 0; fall_n <= 0; armed <= 1'b0; hcnt <= 0; slave_sda <= 1'b1; scl_q <= 1'b1;
    end else if (cmd_valid && cmd_ready) begin
      rise_n <= 0; fall_n <= 0; armed <= 1'b0; hcnt <= 0;
      slave_sda <= (slave_mode == 2) ? slave_byte[7] : 1'b1;
      scl_q <= scl_i;
    end else begin
      if (scl_i && !scl_q) begin
        if (rise_n < 16) cap[rise_n] <= sda_i;
        rise_n <= rise_n + 1;
      end
      if (!scl_i && scl_q) begin
        fall_n <= fall_n + 1;
        if (slave_mode == 2 && fall_n + 1 < 8) slave_sda <= slave_byte[7 - (fall_n + 1)];
        else if (slave_mode == 1 && fall_n + 1 == 8) slave_sda <= 1'b0;
        else slave_sda <= 1'b1;
        if (stretch_en && fall_n + 1 == 4) begin armed <= 1'b1; hcnt <= 0; end
      end
      if (armed && scl_o) begin
        if (hcnt == 19) armed <= 1'b0;
        hcnt <= hcnt + 1;
      end
      scl_q <= scl_i;
    end
  end

  task automatic run_cmd(input i2c_cmd_t c, input logic [7:0] d,
                         output int lat, output int n_done, output int n_arb);
    int cyc;
    bit fin;
    @(negedge clk);
    checks++;
    if (cmd_ready !== 1'b1) begin
      failures++;
      $display("FAIL ready_before_cmd: got %b expected 1", cmd_ready);
    end
    cmd = c; wdata = d; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0; n_done = 0; n_arb = 0; fin = 1'b0; cyc = 0;
    while (!fin && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      if (done_o === 1'b1) begin n_done++; lat = cyc; fin = 1'b1; end
      if (arb_lost_o === 1'b1) begin n_arb++; fin = 1'b1; end
    end
    checks++;
    if (!fin) begin
      failures++;
      $display("FAIL cmd_timeout: got no done/arb after %0d cycles expected completion", cyc);
    end
    repeat (40) begin
      @(posedge clk); #1;
      if (done_o === 1'b1) n_done++;
      if (arb_lost_o === 1'b1) n_arb++;
    end
  endtask

  task automatic test_reset();
    int exp;
    sb_q.push_back(32'h70);
    sb_q.push_back(32'h00);
    rst_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    checks++;
    if ({cmd_ready, scl_o, sda_o, done_o, nack_o, arb_lost_o, bus_busy_o} !== exp[6:0]) begin
      failures++;
      $display("FAIL reset_flags: got %b expected %b",
               {cmd_ready, scl_o, sda_o, done_o, nack_o, arb_lost_o, bus_busy_o}, exp[6:0]);
    end
    exp = sb_q.pop_front();
    checks++;
    if (rdata !== exp[7:0]) begin
      failures++;
      $display("FAIL reset_rdata: got %h expected %h", rdata, exp[7:0]);
    end
    rst_i = 1'b1;
  endtask

  task automatic do_start(input string tag);
    int lat, nd, na, exp;
    slave_mode = 0;
    sb_q.push_back(1 + 4 * CD);
    sb_q.push_back(32'b100);
    run_cmd(CMD_START, 8'h00, lat, nd, na);
    exp = sb_q.pop_front();
    checks++;
    if (lat !== exp) begin
      failures++;
      $display("FAIL %s_start_latency: got %0d expected %0d", tag, lat, exp);
    end
    exp = sb_q.pop_front();
    checks++;
    if ({bus_busy_o, scl_o, sda_o} !== exp[2:0]) begin
      failures++;
      $display("FAIL %s_start_bus: got %b expected %b", tag, {bus_busy_o, scl_o, sda_o}, exp[2:0]);
    end
  endtask

  // Issues a WRITE and checks latency, captured bits, ACK, done count and busy.
  task automatic do_write(input string tag, input logic [7:0] d, input int ack_bit, input int extra);
    int lat, nd, na, exp;
    sb_q.push_back(1 + 36 * CD + extra);
    for (int i = 0; i < 8; i++) sb_q.push_back(int'(d[7 - i]));
    sb_q.push_back(ack_bit);
    sb_q.push_back(1);
    run_cmd(CMD_WRITE, d, lat, nd, na);
    exp = sb_q.pop_front();
    checks++;
    if (lat !== exp) begin
      failures++;
      $display("FAIL %s_latency: got %0d expected %0d", tag, lat, exp);
    end
    for (int i = 0; i < 8; i++) begin
      exp = sb_q.pop_front();
      checks++;
      if (cap[i] !== exp[0]) begin
        failures++;
        $display("FAIL %s_bit%0d: got %b expected %b", tag, 7 - i, cap[i], exp[0]);
      end
    end
    exp = sb_q.pop_front();
    checks++;
    if (nack_o !== exp[0]) begin
      failures++;
      $display("FAIL %s_nack: got %b expected %b", tag, nack_o, exp[0]);
    end
    exp = sb_q.pop_front();
    checks++;
    if (nd !== exp || bus_busy_o !== 1'b1) begin
      failures++;
      $display("FAIL %s_done_busy: got done=%0d busy=%b expected done=%0d busy=1",
               tag, nd, bus_busy_o, exp);
    end
  endtask

  task automatic test_start_write();
    do_start("sw");
    slave_mode = 1;
    do_write("write_a4", 8'hA4, 0, 0);
  endtask

  task automatic test_write_noslave();
    slave_mode = 0;
    do_write("write_55", 8'h55, 1, 0);
  endtask

  task automatic test_read_stop();
    int lat, nd, na, exp;
    slave_mode = 2;
    slave_byte = 8'h3C;
    sb_q.push_back(1 + 36 * CD);
    sb_q.push_back(32'h3C);
    sb_q.push_back(1);
    run_cmd(CMD_READ_NACK, 8'h00, lat, nd, na);
    exp = sb_q.pop_front();
    checks++;
    if (lat !== exp || nd !== 1) begin
      failures++;
      $display("FAIL read_latency: got %0d/%0d done expected %0d/1", lat, nd, exp);
    end
    exp = sb_q.pop_front();
    checks++;
    if (rdata !== exp[7:0]) begin
      failures++;
      $display("FAIL read_data: got %h expected %h", rdata, exp[7:0]);
    end
    exp = sb_q.pop_front();
    checks++;
    if (cap[8] !== exp[0]) begin
      failures++;
      $display("FAIL read_nack_bit: got %b expected %b", cap[8], exp[0]);
    end
    slave_mode = 0;
    sb_q.push_back(1 + 4 * CD);
    sb_q.push_back(32'b011);
    run_cmd(CMD_STOP, 8'h00, lat, nd, na);
    exp = sb_q.pop_front();
    checks++;
    if (lat !== exp) begin
      failures++;
      $display("FAIL stop_latency: got %0d expected %0d", lat, exp);
    end
    exp = sb_q.pop_front();
    checks++;
    if ({bus_busy_o, scl_o, sda_o} !== exp[2:0] || rdata !== 8'h3C) begin
      failures++;
      $display("FAIL stop_bus: got %b rdata %h expected %b rdata 3c",
               {bus_busy_o, scl_o, sda_o}, rdata, exp[2:0]);
    end
  endtask

  task automatic test_stretch();
    do_start("st");
    slave_mode = 1;
    stretch_en = 1'b1;
    do_write("stretch_c5", 8'hC5, 0, 20);
    stretch_en = 1'b0;
  endtask

  task automatic test_arbitration();
    int lat, nd, na, exp;
    slave_mode = 0;
    force_low = 1'b1;
    sb_q.push_back(1);
    sb_q.push_back(0);
    sb_q.push_back(32'b011);
    run_cmd(CMD_WRITE, 8'hFF, lat, nd, na);
    force_low = 1'b0;
    exp = sb_q.pop_front();
    checks++;
    if (na !== exp) begin
      failures++;
      $display("FAIL arb_pulses: got %0d expected %0d", na, exp);
    end
    exp = sb_q.pop_front();
    checks++;
    if (nd !== exp) begin
      failures++;
      $display("FAIL arb_no_done: got %0d expected %0d", nd, exp);
    end
    exp = sb_q.pop_front();
    checks++;
    if ({bus_busy_o, scl_o, sda_o} !== exp[2:0]) begin
      failures++;
      $display("FAIL arb_bus: got %b expected %b", {bus_busy_o, scl_o, sda_o}, exp[2:0]);
    end
  endtask

  task automatic test_reset_mid_read();
    int exp;
    do_start("rr");
    slave_mode = 2;
    slave_byte = 8'h81;
    sb_q.push_back(0);
    sb_q.push_back(32'h70);
    sb_q.push_back(32'h00);
    @(negedge clk);
    cmd = CMD_READ_ACK; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (60) @(posedge clk);
    #1;
    exp = sb_q.pop_front();
    checks++;
    if (cmd_ready !== exp[0]) begin
      failures++;
      $display("FAIL busy_ready: got %b expected %b", cmd_ready, exp[0]);
    end
    rst_i = 1'b0;
    @(posedge clk); #1;
    exp = sb_q.pop_front();
    checks++;
    if ({cmd_ready, scl_o, sda_o, done_o, nack_o, arb_lost_o, bus_busy_o} !== exp[6:0]) begin
      failures++;
      $display("FAIL midreset_flags: got %b expected %b",
               {cmd_ready, scl_o, sda_o, done_o, nack_o, arb_lost_o, bus_busy_o}, exp[6:0]);
    end
    exp = sb_q.pop_front();
    checks++;
    if (rdata !== exp[7:0]) begin
      failures++;
      $display("FAIL midreset_rdata: got %h expected %h", rdata, exp[7:0]);
    end
    rst_i = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if ({scl_o, sda_o, done_o, cmd_ready} !== 4'b1101) begin
      failures++;
      $display("FAIL after_reset_idle: got %b expected 1101", {scl_o, sda_o, done_o, cmd_ready});
    end
  endtask

  initial begin
    test_reset();
    test_start_write();
    test_write_noslave();
    test_read_stop();
    test_stretch();
    test_arbitration();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/i2c_byte_master.md
I2C_BYTE_MASTER -- requirements
Module: i2c_byte_master

Interface
REQ-001 SHALL have parameter CLK_DIV, default 250; system clocks per SCL quarter-period (100 MHz clk -> 100 kHz SCL); legal range 2..65535.
REQ-002 SHALL have port clk_i  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port cmd_i  input  3  command code of type i2c_cmd_t: START, STOP, WRITE, READ_ACK, READ_NACK.
REQ-005 SHALL have port cmd_valid_i  input  1  command request.
REQ-006 SHALL have port cmd_ready_o  output  1  command accepted when high together with cmd_valid_i.
REQ-007 SHALL have port wdata_i  input  8  byte for WRITE, captured on accept.
REQ-008 SHALL have port rdata_o  output  8  byte received by the last READ_ACK or READ_NACK.
REQ-009 SHALL have port done_o  output  1  one-cycle pulse at command completion.
REQ-010 SHALL have port nack_o  output  1  ACK bit sampled by the last WRITE (1 = NACK).
REQ-011 SHALL have port arb_lost_o  output  1  one-cycle pulse on arbitration loss.
REQ-012 SHALL have port bus_busy_o  output  1  high from START completion until STOP completion.
REQ-013 SHALL have ports scl_i and sda_i  input  1 each  sampled bus lines.
REQ-014 SHALL have ports scl_o and sda_o  output  1 each  open-drain intent: 0 = drive low, 1 = release.

Function
REQ-015 SHALL use FSM states IDLE, START, WRITE, READ, STOP; cmd_ready_o = 1 only in IDLE.
REQ-016 SHALL, on accept in IDLE, enter the commanded state on the next cycle, with phase = 0 and bit index = 8.
REQ-017 SHALL advance phase 0->1->2->3 every CLK_DIV cycles via the quarter timer.
REQ-018 SHALL implement clock stretching: in phases 1-2 with scl_o = 1 and scl_i = 0, hold the timer.
REQ-019 START: (scl,sda) per phase = (1,1), (1,0), (0,0), (0,0); set bus_busy_o at completion.
REQ-020 STOP: (scl,sda) per phase = (0,0), (1,0), (1,1), (1,1); clear bus_busy_o at completion.
REQ-021 Bit cell: scl = 0, 1, 1, 0 per phase; sda changes only at phase-0 entry; sda_i sampled on the last cycle of phase 1.
REQ-022 WRITE: 8 bits MSB first, then a 9th bit with SDA released; nack_o = sampled 9th bit.
REQ-023 READ: SDA released for 8 bits, shifted MSB first into rdata_o; 9th bit driven 0 for READ_ACK, released for READ_NACK.
REQ-024 SHALL pulse done_o for one cycle after the last phase of every command, then return to IDLE; latency from accept = 1 + 4*CLK_DIV (START/STOP) or 1 + 36*CLK_DIV (byte), excluding stretch.
REQ-025 Arbitration: if WRITE data bits drive sda_o = 1 but sample sda_i = 0, then pulse arb_lost_o, release both lines, clear bus_busy_o, return to IDLE, and do not pulse done_o.
REQ-026 SHALL not check the ACK bit for arbitration loss.
REQ-027 rdata_o and nack_o SHALL hold until overwritten by the next READ or WRITE respectively.
REQ-028 Any command is accepted regardless of bus_busy_o (a repeated START is legal); the START waveform begins with SCL low-to-high release.

Reset
REQ-029 Reset low SHALL, at the next clock edge, abort any operation and force IDLE, scl_o = 1, sda_o = 1, cmd_ready_o = 1, done_o = 0, nack_o = 0, arb_lost_o = 0, bus_busy_o = 0, rdata_o = 8'h00, and clear the timer.
REQ-030 Reset mid-byte SHALL release the bus without generating a STOP.

Structure
REQ-031 i2c_cmd_t enum and default CLK_DIV constant SHALL live in shared package i2c_types_pkg.
REQ-032 SHALL instantiate one sub-module i2c_quarter_timer (down-counter, hold input, tick output).

Verification (CLK_DIV = 4, bench slave model on open-drain bus)
REQ-033 START then WRITE 8'hA4 with slave ACK -> SDA bits 1,0,1,0,0,1,0,0; nack_o = 0; done_o exactly 145 cycles after accept.
REQ-034 WRITE 8'h55 with no slave -> nack_o = 1; done_o pulses; bus_busy_o stays 1.
REQ-035 READ_NACK with slave sending 8'h3C -> rdata_o = 8'h3C; 9th-bit SDA released; then STOP -> bus_busy_o = 0.
REQ-036 Slave holds SCL low 20 cycles in bit 3 phase 1 -> done_o delayed by exactly 20 cycles; data intact.
REQ-037 WRITE 8'hFF with external SDA forced low on bit 7 -> arb_lost_o pulses once, scl_o = sda_o = 1, no done_o, bus_busy_o = 0.
REQ-038 rst_i low mid READ_ACK -> next cycle cmd_ready_o = 1 and all outputs at reset values.
